// File: rtl/score_pkg.sv
// Shared grade encodings, base-point values and tier limit for the score accumulator.
// Used by score_lane (points/combo/saturation) and score_accumulator (top).
package score_pkg;

  localparam logic [1:0] GRADE_MISS    = 2'b00;
  localparam logic [1:0] GRADE_OK      = 2'b01;
  localparam logic [1:0] GRADE_GOOD    = 2'b10;
  localparam logic [1:0] GRADE_PERFECT = 2'b11;

  localparam logic [2:0] PTS_MISS    = 3'd0;
  localparam logic [2:0] PTS_OK      = 3'd1;
  localparam logic [2:0] PTS_GOOD    = 3'd2;
  localparam logic [2:0] PTS_PERFECT = 3'd4;

  localparam int unsigned MAX_TIER = 2;

  function automatic logic [2:0] base_points(input logic [1:0] grade);
    logic [2:0] pts;
    case (grade)
      GRADE_OK:      pts = PTS_OK;
      GRADE_GOOD:    pts = PTS_GOOD;
      GRADE_PERFECT: pts = PTS_PERFECT;
      default:       pts = PTS_MISS;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_lane.sv
// One player channel: tiered points, saturating combo counter and clamped score
// with a sticky saturation flag.
module score_lane
  import score_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned CW         = 4,
  parameter int unsigned COMBO_STEP = 4
) (
  input  logic          C,
  input  logic          INIT,
  input  logic          hit_valid,
  input  logic [1:0]    hit_grade,
  input  logic          clr,
  output logic [W-1:0]  score,
  output logic [CW-1:0] combo,
  output logic          sat
);

  // Tier comes from the combo value before the current hit is counted.
  function automatic logic [1:0] tier_of(input logic [CW-1:0] c);
    int unsigned q;
    q = 32'(c) / COMBO_STEP;
    return (q >= MAX_TIER) ? 2'(MAX_TIER) : 2'(q);
  endfunction

  logic [2:0] base;
  logic [1:0] tier;
  logic [W:0] points;
  logic [W:0] sum;
  logic       combo_full;

  // Largest award is 4 << 2 = 16, which fits in W+1 bits for every legal W.
  assign base       = base_points(hit_grade);
  assign tier       = tier_of(combo);
  assign points     = {{(W-2){1'b0}}, base} << tier;
  assign sum        = {1'b0, score} + points;
  assign combo_full = &combo;

  always_ff @(posedge C or posedge INIT) begin
    if (INIT) begin
      score <= '0;
      combo <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      score <= '0;
      combo <= '0;
      sat   <= 1'b0;
    end else if (hit_valid) begin
      if (hit_grade == GRADE_MISS) begin
        combo <= '0;
      end else begin
        if (sum[W]) begin
          score <= '1;
          sat   <= 1'b1;
        end else begin
          score <= sum[W-1:0];
        end
        if (!combo_full) begin
          combo <= combo + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/score_accumulator.sv
// Multi-channel score accumulator: CH independent score_lane instances plus an
// optional high-score tracker, compiled in only when SCORE_HIGH_EN is defined.
module score_accumulator
  import score_pkg::*;
#(
  parameter int unsigned CH         = 2,
  parameter int unsigned W          = 8,
  parameter int unsigned CW         = 4,
  parameter int unsigned COMBO_STEP = 4
) (
  input  logic             C,
  input  logic             INIT,
  input  logic [CH-1:0]    hit_valid,
  input  logic [2*CH-1:0]  hit_grade,
  input  logic             clr,
  output logic [CH*W-1:0]  score,
  output logic [CH*CW-1:0] combo,
  output logic [CH-1:0]    sat,
  output logic [W-1:0]     high_score
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    score_lane #(
      .W          (W),
      .CW         (CW),
      .COMBO_STEP (COMBO_STEP)
    ) u_lane (
      .C         (C),
      .INIT      (INIT),
      .hit_valid (hit_valid[gi]),
      .hit_grade (hit_grade[2*gi +: 2]),
      .clr       (clr),
      .score     (score[gi*W +: W]),
      .combo     (combo[gi*CW +: CW]),
      .sat       (sat[gi])
    );
  end

`ifdef SCORE_HIGH_EN
  logic [W-1:0] high_reg;
  logic [W-1:0] high_next;

  // Folding the current high value into the max makes the register monotonic;
  // clr does not touch it, only INIT does.
  always_comb begin
    high_next = high_reg;
    for (int k = 0; k < CH; k++) begin
      if (score[k*W +: W] > high_next) begin
        high_next = score[k*W +: W];
      end
    end
  end

  always_ff @(posedge C or posedge INIT) begin
    if (INIT) begin
      high_reg <= '0;
    end else begin
      high_reg <= high_next;
    end
  end

  assign high_score = high_reg;
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_score_accumulator.sv
// Directed testbench for score_accumulator with CH=2, W=8, CW=4, COMBO_STEP=4.
// High-score expectations follow the SCORE_HIGH_EN build option.
module tb_score_accumulator;

  localparam logic [1:0] MISS = 2'b00;
  localparam logic [1:0] OK   = 2'b01;
  localparam logic [1:0] GOOD = 2'b10;
  localparam logic [1:0] PERF = 2'b11;

`ifdef SCORE_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic        C;
  logic        INIT;
  logic [1:0]  hit_valid;
  logic [3:0]  hit_grade;
  logic        clr;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [1:0]  sat;
  logic [7:0]  high_score;

  int errors = 0;
  int checks = 0;

  score_accumulator #(.CH(2), .W(8), .CW(4), .COMBO_STEP(4)) dut (
    .C          (C),
    .INIT       (INIT),
    .hit_valid  (hit_valid),
    .hit_grade  (hit_grade),
    .clr        (clr),
    .score      (score),
    .combo      (combo),
    .sat        (sat),
    .high_score (high_score)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic logic [7:0] sc(input int k);
    return score[k*8 +: 8];
  endfunction

  function automatic logic [3:0] cb(input int k);
    return combo[k*4 +: 4];
  endfunction

  function automatic logic [7:0] hs_exp(input logic [7:0] v);
    return HIGH_EN ? v : 8'd0;
  endfunction

  // One transaction: inputs applied on the falling edge, outputs sampled 1ns after the rising edge.
  task automatic drive(input logic [1:0] v, input logic [1:0] g0, input logic [1:0] g1, input logic c);
    @(negedge C);
    hit_valid = v;
    hit_grade = {g1, g0};
    clr       = c;
    @(posedge C);
    #1;
    $display("t=%0t valid=%b grade=%b clr=%b score0=%0d score1=%0d combo0=%0d combo1=%0d sat=%b high=%0d",
             $time, v, {g1, g0}, c, sc(0), sc(1), cb(0), cb(1), sat, high_score);
    hit_valid = '0;
    clr       = 1'b0;
  endtask

  task automatic test_reset();
    INIT = 1'b1; hit_valid = '0; hit_grade = '0; clr = 1'b0;
    repeat (2) @(posedge C);
    @(negedge C); INIT = 1'b0;
    drive(2'b01, PERF, MISS, 1'b0);
    drive(2'b00, MISS, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd4) begin errors++; $display("FAIL pre_init_score0: got %0d expected 4", sc(0)); end
    // Asynchronous reset in mid-cycle with a hit pending.
    @(negedge C); #2;
    INIT = 1'b1; hit_valid = 2'b01; hit_grade = {MISS, PERF};
    #1;
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL init_score: got %h expected 0000", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL init_combo: got %h expected 00", combo); end
    checks++; if (sat !== 2'b00) begin errors++; $display("FAIL init_sat: got %b expected 00", sat); end
    checks++; if (high_score !== 8'd0) begin errors++; $display("FAIL init_high: got %0d expected 0", high_score); end
    @(posedge C); #1;
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL init_discard: got %h expected 0000", score); end
    @(negedge C); INIT = 1'b0;
    @(posedge C); #1;
    checks++; if (sc(0) !== 8'd4 || cb(0) !== 4'd1) begin errors++; $display("FAIL post_init_hit: got score %0d combo %0d expected 4/1", sc(0), cb(0)); end
    hit_valid = '0;
  endtask

  task automatic test_perfect_ramp();
    logic [7:0] exp_s [5];
    exp_s = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd24};
    drive(2'b00, MISS, MISS, 1'b1);
    checks++; if (score !== 16'd0 || combo !== 8'd0) begin errors++; $display("FAIL clr_state: got score %h combo %h expected 0", score, combo); end
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, PERF, MISS, 1'b0);
      checks++; if (sc(0) !== exp_s[i]) begin errors++; $display("FAIL ramp_score[%0d]: got %0d expected %0d", i, sc(0), exp_s[i]); end
      checks++; if (cb(0) !== 4'(i + 1)) begin errors++; $display("FAIL ramp_combo[%0d]: got %0d expected %0d", i, cb(0), i + 1); end
    end
    checks++; if (sc(1) !== 8'd0 || cb(1) !== 4'd0) begin errors++; $display("FAIL ramp_ch1_idle: got %0d/%0d expected 0/0", sc(1), cb(1)); end
  endtask

  task automatic test_good_miss();
    repeat (3) drive(2'b01, PERF, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd48 || cb(0) !== 4'd8) begin errors++; $display("FAIL reach_combo8: got %0d/%0d expected 48/8", sc(0), cb(0)); end
    drive(2'b01, GOOD, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd56 || cb(0) !== 4'd9) begin errors++; $display("FAIL good_x4_a: got %0d/%0d expected 56/9", sc(0), cb(0)); end
    drive(2'b01, GOOD, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd64 || cb(0) !== 4'd10) begin errors++; $display("FAIL good_x4_b: got %0d/%0d expected 64/10", sc(0), cb(0)); end
    drive(2'b00, PERF, PERF, 1'b0);
    checks++; if (sc(0) !== 8'd64 || cb(0) !== 4'd10) begin errors++; $display("FAIL no_valid_hold: got %0d/%0d expected 64/10", sc(0), cb(0)); end
    drive(2'b01, MISS, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd64 || cb(0) !== 4'd0) begin errors++; $display("FAIL miss: got %0d/%0d expected 64/0", sc(0), cb(0)); end
    drive(2'b01, OK, MISS, 1'b0);
    checks++; if (sc(0) !== 8'd65 || cb(0) !== 4'd1) begin errors++; $display("FAIL ok_after_miss: got %0d/%0d expected 65/1", sc(0), cb(0)); end
  endtask

  task automatic test_combo_sat();
    repeat (16) drive(2'b10, MISS, OK, 1'b0);
    checks++; if (sc(1) !== 8'd44 || cb(1) !== 4'd15) begin errors++; $display("FAIL combo_cap: got %0d/%0d expected 44/15", sc(1), cb(1)); end
    drive(2'b10, MISS, OK, 1'b0);
    checks++; if (sc(1) !== 8'd48 || cb(1) !== 4'd15) begin errors++; $display("FAIL combo_hold: got %0d/%0d expected 48/15", sc(1), cb(1)); end
    checks++; if (sc(0) !== 8'd65 || cb(0) !== 4'd1) begin errors++; $display("FAIL ch0_independent: got %0d/%0d expected 65/1", sc(0), cb(0)); end
  endtask

  task automatic test_saturation();
    drive(2'b00, MISS, MISS, 1'b1);
    repeat (19) drive(2'b10, MISS, PERF, 1'b0);
    checks++; if (sc(1) !== 8'd224 || cb(1) !== 4'd15) begin errors++; $display("FAIL sat_build_a: got %0d/%0d expected 224/15", sc(1), cb(1)); end
    drive(2'b10, MISS, MISS, 1'b0);
    drive(2'b10, MISS, GOOD, 1'b0);
    drive(2'b10, MISS, PERF, 1'b0);
    drive(2'b10, MISS, PERF, 1'b0);
    drive(2'b10, MISS, MISS, 1'b0);
    repeat (9) drive(2'b10, MISS, OK, 1'b0);
    checks++; if (sc(1) !== 8'd250 || cb(1) !== 4'd9 || sat !== 2'b00) begin errors++; $display("FAIL sat_pre: got %0d/%0d sat %b expected 250/9 sat 00", sc(1), cb(1), sat); end
    drive(2'b10, MISS, PERF, 1'b0);
    checks++; if (sc(1) !== 8'd255 || sat !== 2'b10) begin errors++; $display("FAIL sat_clamp: got %0d sat %b expected 255 sat 10", sc(1), sat); end
    drive(2'b10, MISS, OK, 1'b0);
    checks++; if (sc(1) !== 8'd255 || sat !== 2'b10) begin errors++; $display("FAIL sat_sticky: got %0d sat %b expected 255 sat 10", sc(1), sat); end
    checks++; if (high_score !== hs_exp(8'd255)) begin errors++; $display("FAIL high_at_sat: got %0d expected %0d", high_score, hs_exp(8'd255)); end
    drive(2'b00, MISS, MISS, 1'b1);
    checks++; if (score !== 16'd0 || sat !== 2'b00 || combo !== 8'd0) begin errors++; $display("FAIL sat_clr: got score %h sat %b combo %h expected 0", score, sat, combo); end
    drive(2'b00, MISS, MISS, 1'b0);
    checks++; if (high_score !== hs_exp(8'd255)) begin errors++; $display("FAIL high_keep_clr: got %0d expected %0d", high_score, hs_exp(8'd255)); end
  endtask

  task automatic test_high_score();
    @(negedge C); INIT = 1'b1; #1;
    checks++; if (high_score !== 8'd0) begin errors++; $display("FAIL high_init: got %0d expected 0", high_score); end
    @(negedge C); INIT = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive({1'b1, (i < 7) ? 1'b1 : 1'b0}, PERF, (i < 8) ? PERF : ((i == 8) ? OK : GOOD), 1'b0);
    end
    checks++; if (sc(0) !== 8'd40 || sc(1) !== 8'd60) begin errors++; $display("FAIL high_scores: got %0d/%0d expected 40/60", sc(0), sc(1)); end
    checks++; if (high_score !== hs_exp(8'd52)) begin errors++; $display("FAIL high_lat1: got %0d expected %0d", high_score, hs_exp(8'd52)); end
    drive(2'b00, MISS, MISS, 1'b0);
    checks++; if (high_score !== hs_exp(8'd60)) begin errors++; $display("FAIL high_lat2: got %0d expected %0d", high_score, hs_exp(8'd60)); end
  endtask

  task automatic test_back_to_back();
    drive(2'b11, PERF, PERF, 1'b1);
    checks++; if (score !== 16'd0 || combo !== 8'd0) begin errors++; $display("FAIL clr_wins: got score %h combo %h expected 0", score, combo); end
    drive(2'b11, PERF, PERF, 1'b0);
    checks++; if (sc(0) !== 8'd4 || sc(1) !== 8'd4 || combo !== 8'h11) begin errors++; $display("FAIL after_clr_base: got %0d/%0d combo %h expected 4/4 combo 11", sc(0), sc(1), combo); end
    drive(2'b11, GOOD, OK, 1'b0);
    checks++; if (sc(0) !== 8'd6 || sc(1) !== 8'd5 || combo !== 8'h22) begin errors++; $display("FAIL both_lanes: got %0d/%0d combo %h expected 6/5 combo 22", sc(0), sc(1), combo); end
    checks++; if (high_score !== hs_exp(8'd60)) begin errors++; $display("FAIL high_no_decrease: got %0d expected %0d", high_score, hs_exp(8'd60)); end
  endtask

  initial begin
    test_reset();
    test_perfect_ramp();
    test_good_miss();
    test_combo_sat();
    test_saturation();
    test_high_score();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
